// File: rtl/strm_pkg.sv
// Shared types and constants for the streaming read arbiter.
package strm_pkg;

  localparam int unsigned ID_W   = 16;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned DATA_W = 512;

  localparam logic [2:0] ARSIZE_64B = 3'b110;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ar_req_t;

endpackage

// File: rtl/strm_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping modulo N.
module strm_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          found
);

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin : pick
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + (N - 1 - k)) % N;
      if (elig[IW'(idx)]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/strm_rd_arb.sv
// Multi-requester AXI read arbiter: round-robin AR issue, per-ID outstanding limit, R routing by ID.
// Optional statistics counters are enabled with STRM_RD_ARB_STATS_EN.
module strm_rd_arb
  import strm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [ID_W-1:0]           m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [LEN_W-1:0]          m_arlen,
  output logic [2:0]                m_arsize,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_rlast,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic                      err_rid
`ifdef STRM_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     grant_cnt,
  output logic [63:0]               busy_cycles
`endif
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = 8;

  arb_state_e         state;
  logic [IW-1:0]      rr_ptr;
  ar_req_t            ar_q;
  logic [CW-1:0]      out_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] ar_inc;
  logic [NUM_REQ-1:0] r_dec;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               ar_hs;
  logic               rid_ok;
  logic               r_done;
  logic [IW-1:0]      rid_idx;

  assign ar_hs    = m_arvalid && m_arready;
  assign rid_ok   = 32'(m_rid) < NUM_REQ;
  assign rid_idx  = m_rid[IW-1:0];
  assign r_done   = m_rvalid && m_rready && m_rlast && rid_ok;
  assign m_arid   = ar_q.id;
  assign m_araddr = ar_q.addr;
  assign m_arlen  = ar_q.len;
  assign m_arsize = ARSIZE_64B;

  strm_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .found (pick_found)
  );

  // Per-requester eligibility and outstanding burst accounting.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign elig[g]   = req_arvalid[g] && (32'(out_cnt[g]) < MAX_OUT);
    assign ar_inc[g] = ar_hs && (ar_q.id == ID_W'(g));
    assign r_dec[g]  = r_done && (rid_idx == IW'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_cnt[g] <= '0;
      end else if (ar_inc[g] && !r_dec[g] && (out_cnt[g] != '1)) begin
        out_cnt[g] <= out_cnt[g] + CW'(1);
      end else if (r_dec[g] && !ar_inc[g] && (out_cnt[g] != '0)) begin
        out_cnt[g] <= out_cnt[g] - CW'(1);
      end
    end
  end

  // AR issue FSM; a handshake cycle never overlaps a new selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      ar_q        <= '0;
      m_arvalid   <= 1'b0;
      req_arready <= '0;
    end else begin
      req_arready <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            req_arready[pick_idx] <= 1'b1;
            ar_q.id   <= ID_W'(pick_idx);
            ar_q.addr <= req_araddr[32'(pick_idx)*ADDR_W +: ADDR_W];
            ar_q.len  <= req_arlen[32'(pick_idx)*LEN_W +: LEN_W];
            m_arvalid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            rr_ptr    <= IW'((32'(ar_q.id) + 32'd1) % NUM_REQ);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // R routing by ID; unknown IDs are accepted and dropped.
  always_comb begin
    req_rvalid = '0;
    m_rready   = 1'b1;
    req_rdata  = m_rdata;
    req_rlast  = m_rlast;
    if (rid_ok) begin
      req_rvalid[rid_idx] = m_rvalid;
      m_rready            = req_rready[rid_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_rid <= 1'b0;
    end else if (m_rvalid && !rid_ok) begin
      err_rid <= 1'b1;
    end
  end

`ifdef STRM_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0] busy_vec;
  logic [31:0]        gcnt [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign busy_vec[g]          = out_cnt[g] != '0;
    assign grant_cnt[g*32 +: 32] = gcnt[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gcnt[g] <= '0;
      end else if (ar_inc[g] && (gcnt[g] != '1)) begin
        gcnt[g] <= gcnt[g] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cycles <= '0;
    end else if (|busy_vec) begin
      busy_cycles <= busy_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_strm_rd_arb.sv
// Randomized scoreboard bench for strm_rd_arb with a cycle-level reference model and directed scenarios.
module tb_strm_rd_arb;
  import strm_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned MO = 2;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req_arvalid;
  logic [N*64-1:0]    req_araddr;
  logic [N*8-1:0]     req_arlen;
  logic [N-1:0]       req_arready;
  logic [15:0]        m_arid;
  logic [63:0]        m_araddr;
  logic [7:0]         m_arlen;
  logic [2:0]         m_arsize;
  logic               m_arvalid;
  logic               m_arready;
  logic [15:0]        m_rid;
  logic [511:0]       m_rdata;
  logic               m_rlast;
  logic               m_rvalid;
  logic               m_rready;
  logic [N-1:0]       req_rvalid;
  logic [511:0]       req_rdata;
  logic               req_rlast;
  logic [N-1:0]       req_rready;
  logic               err_rid;

  strm_rd_arb #(.NUM_REQ(N), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rlast(req_rlast),
    .req_rready(req_rready), .err_rid(err_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    int id;
    int len;
  } burst_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (owned by the monitor).
  int       mdl_out [N];
  int       mdl_ptr;
  bit       mdl_issue;
  bit       mdl_err;
  logic [N-1:0] exp_pulse;
  ar_t      exp_q[$];
  burst_t   resp_q[$];
  int       cyc = 0;
  int       gl_id[$];
  int       gl_cyc[$];

  // Driver state.
  logic         arv [N];
  logic [63:0]  aaddr [N];
  logic [7:0]   alen [N];
  logic [N-1:0] hold_mask;
  bit           rnd_mode;
  bit           r_en;
  int           r_beat;
  int           gcount [N];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_data(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data differs, got low word %0h expected %0h", nm, act[63:0], exp[63:0]);
    end
  endfunction

  function automatic void fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or expected event absent, got none expected event", nm);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void new_payload(input int i);
    aaddr[i] = {$urandom, $urandom} & ~64'h3F;
    alen[i]  = 8'($urandom_range(0, 3));
  endfunction

  function automatic void drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_arvalid[i]          = arv[i];
      req_araddr[i*64 +: 64]  = aaddr[i];
      req_arlen[i*8 +: 8]     = alen[i];
    end
  endfunction

  // Monitor: checks outputs against the model, then advances the model across the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (rst) begin
        for (int i = 0; i < N; i++) mdl_out[i] = 0;
        mdl_ptr = 0; mdl_issue = 0; mdl_err = 0; exp_pulse = '0;
        exp_q.delete();
        resp_q.delete();
      end else begin
        int  sel;
        bit  hs;
        ar_t a;
        chk("m_arvalid", 64'(m_arvalid), 64'(mdl_issue));
        chk("req_arready", 64'(req_arready), 64'(exp_pulse));
        for (int i = 0; i < N; i++)
          if (req_arready[i]) begin gl_id.push_back(i); gl_cyc.push_back(cyc); end
        if (m_arvalid) begin
          if (exp_q.size() == 0) fail("ar_unexpected");
          else begin
            chk("m_arid", 64'(m_arid), 64'(exp_q[0].id));
            chk("m_araddr", m_araddr, exp_q[0].addr);
            chk("m_arlen", 64'(m_arlen), 64'(exp_q[0].len));
            chk("m_arsize", 64'(m_arsize), 64'd6);
          end
        end
        chk("err_rid", 64'(err_rid), 64'(mdl_err));
        if (m_rvalid && m_rid < 16'(N)) begin
          chk("req_rvalid", 64'(req_rvalid), 64'(1) << m_rid);
          chk("m_rready", 64'(m_rready), 64'(req_rready[m_rid[1:0]]));
          chk_data("req_rdata", req_rdata, m_rdata);
          chk("req_rlast", 64'(req_rlast), 64'(m_rlast));
        end else if (m_rvalid) begin
          chk("m_rready_bad", 64'(m_rready), 64'd1);
          chk("req_rvalid_bad", 64'(req_rvalid), 64'd0);
        end else begin
          chk("req_rvalid_idle", 64'(req_rvalid), 64'd0);
        end

        hs  = mdl_issue && m_arready && (exp_q.size() > 0);
        sel = -1;
        if (!mdl_issue) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mdl_ptr + k) % N;
            if (req_arvalid[idx] && mdl_out[idx] < MO) begin sel = idx; break; end
          end
        end
        exp_pulse = '0;
        if (sel >= 0) begin
          exp_pulse[sel] = 1'b1;
          mdl_issue = 1;
          exp_q.push_back('{sel, req_araddr[sel*64 +: 64], req_arlen[sel*8 +: 8]});
        end
        if (hs) begin
          a = exp_q.pop_front();
          mdl_out[a.id]++;
          mdl_ptr = (a.id + 1) % N;
          resp_q.push_back('{a.id, int'(a.len)});
          mdl_issue = 0;
        end
        if (m_rvalid && m_rid < 16'(N) && req_rready[m_rid[1:0]] && m_rlast)
          mdl_out[m_rid[1:0]]--;
        if (m_rvalid && m_rid >= 16'(N)) mdl_err = 1;
      end
    end
  end

  // One driver cycle: react to grants, advance the R responder, drive inputs.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_arready[i]) begin
        gcount[i]++;
        new_payload(i);
        if (rnd_mode) arv[i] = 1'($urandom_range(0, 1));
        else arv[i] = hold_mask[i];
      end else if (rnd_mode && $urandom_range(0, 7) == 0) begin
        arv[i] = ~arv[i];
        new_payload(i);
      end
    end
    if (rst) r_beat = 0;
    else if (m_rvalid && m_rready && m_rid < 16'(N)) begin
      if (m_rlast) begin
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        r_beat = 0;
      end else r_beat++;
    end
    if (r_en && resp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      m_rvalid = 1'b1;
      m_rid    = 16'(resp_q[0].id);
      m_rlast  = (r_beat >= resp_q[0].len);
      m_rdata  = rand512();
    end else begin
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
    end
    if (rnd_mode) begin
      for (int i = 0; i < N; i++) req_rready[i] = ($urandom_range(0, 3) != 0);
      m_arready = ($urandom_range(0, 2) != 0);
    end
    drive_reqs();
  endtask

  task automatic drain(input string nm);
    int quiet;
    quiet = 0;
    rnd_mode = 0; hold_mask = '0; r_en = 1; m_arready = 1'b1; req_rready = '1;
    for (int i = 0; i < N; i++) arv[i] = 1'b0;
    drive_reqs();
    for (int t = 0; t < 4000 && quiet < 3; t++) begin
      step();
      if (resp_q.size() == 0 && exp_q.size() == 0 && !m_arvalid) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) fail(nm);
  endtask

  task automatic wait_arvalid(input string nm);
    int t;
    for (t = 0; t < 20 && !m_arvalid; t++) step();
    if (!m_arvalid) fail(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_alt [4];
    int t;
    exp_alt = '{0, 2, 0, 2};
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin arv[i] = 1'b0; aaddr[i] = '0; alen[i] = '0; gcount[i] = 0; end
    hold_mask = '0; rnd_mode = 0; r_en = 0; r_beat = 0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    req_rready = '1;
    drive_reqs();
    repeat (3) @(negedge clk);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_req_arready", 64'(req_arready), 64'd0);
    chk("rst_err_rid", 64'(err_rid), 64'd0);
    chk("rst_m_araddr", m_araddr, 64'd0);
    chk("rst_m_arlen", 64'(m_arlen), 64'd0);
    chk("rst_m_arid", 64'(m_arid), 64'd0);
    #1 rst = 1'b0;
    step();
    chk("m_arsize_const", 64'(m_arsize), 64'd6);

    // Requesters 0 and 2 always valid: grants alternate, one every two cycles.
    gl_id.delete(); gl_cyc.delete();
    hold_mask = 4'b0101; arv[0] = 1'b1; arv[2] = 1'b1; new_payload(0); new_payload(2);
    m_arready = 1'b1; drive_reqs();
    repeat (12) step();
    if (gl_id.size() < 4) fail("alt_grants");
    else begin
      for (int k = 0; k < 4; k++) chk("alt_grant_id", 64'(gl_id[k]), 64'(exp_alt[k]));
      for (int k = 1; k < 4; k++) chk("alt_grant_gap", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'd2);
    end
    drain("drain_alt");

    rnd_mode = 1; r_en = 1;
    repeat (1500) step();
    drain("drain_rnd");

    // AR stall: payload held for 5 cycles, handshake on the 6th.
    hold_mask = '0; arv[1] = 1'b1; aaddr[1] = 64'h1000; alen[1] = 8'd63;
    m_arready = 1'b0; drive_reqs();
    wait_arvalid("stall_arvalid");
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("stall_arvalid", 64'(m_arvalid), 64'd1);
      chk("stall_araddr", m_araddr, 64'h1000);
      chk("stall_arlen", 64'(m_arlen), 64'd63);
    end
    step();
    m_arready = 1'b1;
    step();
    chk("stall_done", 64'(m_arvalid), 64'd0);
    drain("drain_stall");

    // Outstanding limit: two bursts in flight block requester 1 until one completes.
    for (int i = 0; i < N; i++) gcount[i] = 0;
    r_en = 0; hold_mask = 4'b0010; arv[1] = 1'b1; new_payload(1); m_arready = 1'b1; drive_reqs();
    repeat (12) step();
    chk("maxout_block", 64'(gcount[1]), 64'd2);
    r_en = 1;
    for (t = 0; t < 40 && gcount[1] < 3; t++) step();
    if (gcount[1] < 3) fail("maxout_regrant");
    else chk("maxout_regrant", 64'(gcount[1]), 64'd3);
    drain("drain_maxout");

    // AR handshake and rlast for ID 0 in the same cycle leave the count unchanged.
    for (int i = 0; i < N; i++) gcount[i] = 0;
    r_en = 0; hold_mask = '0; arv[0] = 1'b1; aaddr[0] = 64'h2000; alen[0] = 8'd0;
    m_arready = 1'b1; drive_reqs();
    for (t = 0; t < 20 && gcount[0] < 1; t++) step();
    for (t = 0; t < 20 && m_arvalid; t++) step();
    arv[0] = 1'b1; aaddr[0] = 64'h3000; alen[0] = 8'd0; m_arready = 1'b0; drive_reqs();
    wait_arvalid("simul_arvalid");
    m_arready = 1'b1; m_rvalid = 1'b1; m_rid = 16'd0; m_rlast = 1'b1; m_rdata = rand512();
    req_rready = '1;
    step();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    hold_mask = 4'b0001; arv[0] = 1'b1; new_payload(0); drive_reqs();
    repeat (12) step();
    chk("simul_cnt", 64'(gcount[0]), 64'd1);
    drain("drain_simul");

    // Unknown ID: accepted, not routed, sticky error flag.
    r_en = 0; req_rready = '0;
    step();
    m_rvalid = 1'b1; m_rid = 16'd7; m_rlast = 1'b0; m_rdata = rand512();
    #1;
    chk("badid_m_rready", 64'(m_rready), 64'd1);
    chk("badid_req_rvalid", 64'(req_rvalid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      m_rvalid = 1'b1; m_rid = 16'd7;
    end
    step();
    m_rid = 16'd0;
    repeat (3) step();
    chk("badid_sticky", 64'(err_rid), 64'd1);
    req_rready = '1;
    drain("drain_badid");

    // Reset during ISSUE drops m_arvalid at once; pointer restarts at 0.
    hold_mask = 4'b0100; arv[2] = 1'b1; new_payload(2); m_arready = 1'b0; drive_reqs();
    wait_arvalid("rst_issue_arvalid");
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_mid_err", 64'(err_rid), 64'd0);
    step();
    step();
    hold_mask = '1;
    for (int i = 0; i < N; i++) begin arv[i] = 1'b1; new_payload(i); end
    m_arready = 1'b1; r_en = 1; drive_reqs();
    #1 rst = 1'b0;
    for (t = 0; t < 10 && req_arready == '0; t++) step();
    if (req_arready == '0) fail("post_rst_grant");
    else chk("post_rst_grant", 64'(req_arready), 64'b0001);
    drain("drain_final");
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
